// File: rtl/pr_bridge_ctrl.sv
// Processor-bus to peripheral bridge: decodes the 0x7F00 window, sequences a
// ready/valid access with stall and timeout, and synchronises interrupt lines.
module pr_bridge_ctrl #(
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  input  logic        PrRE,
  output logic [31:0] PrRD,
  output logic        PrStall,
  output logic        BusErr,
  output logic [2:0]  DEV_Sel,
  output logic [1:0]  DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        DEV_WE,
  input  logic [31:0] DEV_RD0,
  input  logic [31:0] DEV_RD1,
  input  logic [31:0] DEV_RD2,
  input  logic [2:0]  DEV_Rdy,
  input  logic [2:0]  DEV_Irq,
  input  logic [2:0]  ExtIrq,
  output logic [7:2]  HWInt
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [5:0]    sync_r [SYNC_STAGES];

  logic          in_window_s;
  logic          valid_s;
  logic          req_s;
  logic          accept_s;
  logic          decerr_s;
  logic          rdy_sel_s;
  logic          last_s;
  logic          timeout_s;
  logic [31:0]   rd_mux_s;
  logic          unused_s;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  assign in_window_s = (PrAddr[31:8] == 24'h00007F);
  assign valid_s     = in_window_s && (PrAddr[7:6] == 2'b00) && (PrAddr[5:4] != 2'b11);
  assign req_s       = PrWE | PrRE;
  assign accept_s    = (state_r == IDLE) && req_s && valid_s;
  assign decerr_s    = (state_r == IDLE) && req_s && in_window_s && !valid_s;
  // DEV_Sel holds the one-hot latched index, so masking with it ignores other devices.
  assign rdy_sel_s   = |(DEV_Rdy & DEV_Sel);
  assign last_s      = (cnt_r == CW'(TIMEOUT - 1));
  assign timeout_s   = (state_r == WAIT) && !rdy_sel_s && last_s;
  assign unused_s    = ^PrAddr[1:0];

  assign PrStall = !reset && ((state_r == WAIT) || accept_s);
  assign BusErr  = !reset && (decerr_s || timeout_s);
  assign HWInt   = sync_r[SYNC_STAGES-1];

  // Read-data select driven by the latched device select.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (DEV_Sel)
      3'b001:  rd_mux_s = DEV_RD0;
      3'b010:  rd_mux_s = DEV_RD1;
      3'b100:  rd_mux_s = DEV_RD2;
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Access sequencer; the DEV_* registers double as the request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      PrRD     <= 32'h0000_0000;
      DEV_Sel  <= 3'b000;
      DEV_Addr <= 2'b00;
      DEV_WD   <= 32'h0000_0000;
      DEV_WE   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= WAIT;
            cnt_r    <= '0;
            DEV_Sel  <= onehot3(PrAddr[5:4]);
            DEV_Addr <= PrAddr[3:2];
            DEV_WD   <= PrWD;
            DEV_WE   <= PrWE;
          end else if (decerr_s) begin
            PrRD <= 32'h0000_0000;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (rdy_sel_s || last_s) begin
            if (!DEV_WE) begin
              PrRD <= rdy_sel_s ? rd_mux_s : 32'h0000_0000;
            end else begin
              PrRD <= PrRD;
            end
            state_r  <= DONE;
            DEV_Sel  <= 3'b000;
            DEV_Addr <= 2'b00;
            DEV_WD   <= 32'h0000_0000;
            DEV_WE   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          DEV_Sel  <= 3'b000;
          DEV_Addr <= 2'b00;
          DEV_WD   <= 32'h0000_0000;
          DEV_WE   <= 1'b0;
        end
      endcase
    end
  end

  // Interrupt synchroniser chain, {ExtIrq, DEV_Irq} per stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 6'b000000;
    end else begin
      sync_r[0] <= {ExtIrq, DEV_Irq};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

endmodule

// File: doc/pr_bridge_ctrl.md
Name: pr_bridge_ctrl

Overview:
Sequencing bridge between the MEM-stage processor bus (PrAddr/PrWD/PrWE/PrRE/PrRD) and three memory-mapped peripherals in window 0x0000_7F00–0x0000_7FFF. It decodes the target device, runs a ready/valid handshake with it, and stalls the pipeline while the access is outstanding. It times out silent devices and synchronises device and external interrupt lines into the 6-bit HWInt vector consumed by CP0.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before abort (must be ≥2)
SYNC_STAGES, 2, flip-flop stages on each interrupt input (fixed ≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
PrAddr  in  32  CPU bus address (non-zero only when inside window)
PrWD  in  32  CPU write data
PrWE  in  1  CPU write request
PrRE  in  1  CPU read request
PrRD  out  32  read data returned to CPU (registered)
PrStall  out  1  freeze IF/ID/EX/MEM while high
BusErr  out  1  one-cycle pulse: unmapped address or timeout
DEV_Sel  out  3  one-hot device select
DEV_Addr  out  2  word offset inside device (PrAddr[3:2])
DEV_WD  out  32  write data to device
DEV_WE  out  1  write strobe to selected device
DEV_RD0/DEV_RD1/DEV_RD2  in  32 each  device read data
DEV_Rdy  in  3  per-device completion
DEV_Irq  in  3  device interrupt levels
ExtIrq  in  3  external interrupt levels
HWInt  out  6  [4:2]=synced DEV_Irq, [7:5]=synced ExtIrq

Behaviour:
- Decode: in-window = PrAddr[31:8]==24'h00007F. Device index = PrAddr[5:4]; valid iff PrAddr[7:6]==0 and index≤2 (dev0 0x7F00, dev1 0x7F10, dev2 0x7F20). req = PrWE|PrRE.
- States IDLE, WAIT, DONE; 2-bit encoding; reset → IDLE.
- IDLE:
  - req and valid: latch index, offset, PrWD, PrWE; go to WAIT. PrStall=1 combinationally in this cycle.
  - req, in-window, invalid: BusErr=1 this cycle, PrRD<=0, no stall, stay IDLE.
  - no req: outputs idle.
- WAIT:
  - PrStall=1. DEV_Sel=one-hot(latched index); DEV_Addr, DEV_WD from latches; DEV_WE=latched write flag.
  - Device holds inputs stable until it asserts Rdy.
  - Wait counter increments each cycle starting from 0.
  - DEV_Rdy[idx]=1: PrRD<=DEV_RDidx on reads (unchanged on writes); go to DONE.
  - Counter==TIMEOUT-1 without Rdy: BusErr=1, PrRD<=0 on reads; go to DONE. Rdy in the same cycle wins (no error).
  - Rdy from non-selected devices is ignored.
- DONE:
  - PrStall=0, so the pipeline advances and the MEM stage samples PrRD. DEV_Sel=0, DEV_WE=0.
  - req still visible this cycle; it is ignored and never restarts an access. Unconditionally go to IDLE.
- Minimum access = 3 cycles (IDLE-accept, WAIT with Rdy, DONE); stall visible for 2.
- Back-to-back requests: the new request is accepted in the IDLE cycle after DONE.
- PrRE and PrWE both high: treat as write.
- Outputs outside WAIT: DEV_Sel=0, DEV_WE=0, DEV_WD=0, DEV_Addr=0.
- Interrupts: each of the 6 lines passes through a SYNC_STAGES-flop synchroniser; HWInt is the last stage, a level not a pulse. Latency is 2 clocks; independent of FSM and stall.
- Reset values, including mid-access reset: state IDLE, counter 0, all latches 0, PrRD=0, PrStall=0, BusErr=0, DEV_* outputs 0, sync flops 0, HWInt=0. Reset is asynchronous: PrStall drops immediately.
- Counter width ceil(log2(TIMEOUT)). The counter clears on entering WAIT and never wraps inside WAIT.

Test Plan:
- Read dev1 at 0x7F14, DEV_RD1=0xDEADBEEF, Rdy after 2 WAIT cycles → DEV_Sel=3'b010, DEV_Addr=2'b01; PrStall high 3 cycles; PrRD=0xDEADBEEF in DONE; BusErr=0.
- Write 0x0000_00FF to 0x7F20, Rdy same cycle as WAIT entry → DEV_WE=1, DEV_Sel=3'b100, DEV_WD=0xFF for one cycle; PrRD unchanged; stall 2 cycles.
- Read 0x7F30 (index 3) and 0x7F44 → BusErr pulse, no stall, DEV_Sel stays 0, PrRD=0.
- Read dev0 with Rdy never asserted, TIMEOUT=16 → 16 WAIT cycles, BusErr pulse on the 16th, PrRD=0, return to IDLE after DONE.
- Reset asserted mid-WAIT (cycle 3) → PrStall and DEV_Sel drop asynchronously; after release the next request starts a fresh 3-cycle access.
- Pulse ExtIrq[1]=1 and DEV_Irq[0]=1 → HWInt[6] and HWInt[2] rise exactly 2 clocks later; deassertion also propagates in 2 clocks, including during a stalled access.
